// File: rtl/fifo_enq_rr_arbiter.sv
// rtl/fifo_enq_rr_arbiter.sv - round-robin arbiter feeding a one-entry sync_fifo enqueue register
// Picks one requester per cycle and holds its payload until the FIFO accepts it.
module fifo_enq_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_enqueue,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_is_full,
  output logic                          busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [PTR_W-1:0]      winner;
  logic [PTR_W:0]        scan_sum;
  logic [PTR_W-1:0]      scan_idx;
  logic                  found;
  logic                  any_req;
  logic                  space;
  logic                  drain;
  logic                  grant_en;
  logic [DATA_WIDTH-1:0] sel_data;

  assign any_req  = |req;
  assign space    = ~out_valid_q | ~fifo_is_full;
  assign drain    = out_valid_q & ~fifo_is_full;
  // rst_n gates the grant so nothing is offered while the register is held in reset
  assign grant_en = rst_n & space & ~flush & any_req;

  always_comb begin
    winner   = rr_ptr_q;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    gnt      = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) begin
        gnt[i]   = grant_en;
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (drain || flush) begin
      out_valid_d = 1'b0;
    end
    // A grant in the same cycle as a drain refills the register back-to-back
    if (grant_en) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      rr_ptr_d    = (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign fifo_enqueue = out_valid_q;
  assign fifo_wdata   = out_data_q;
  assign busy         = out_valid_q | any_req;

endmodule

// File: tb/tb_fifo_enq_rr_arbiter.sv
// tb/tb_fifo_enq_rr_arbiter.sv - self-checking bench for fifo_enq_rr_arbiter
// Queue-based reference model, per-cycle compare, directed literals and a random scoreboard run.
module tb_fifo_enq_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     gnt;
  logic              fifo_enqueue;
  logic [DW-1:0]     fifo_wdata;
  logic              fifo_is_full = 1'b0;
  logic              busy;

  logic [DW-1:0]     pdata [NR];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]     m_q[$];
  logic [DW-1:0]     m_last = '0;
  int                m_ptr = 0;
  logic [NR-1:0]     m_gmask = '0;
  int                m_acc_n = 0;
  logic [DW-1:0]     m_acc_sum = '0;
  int                m_drop = 0;
  int                d_acc_n = 0;
  logic [DW-1:0]     d_acc_sum = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pdata[i];
  end

  fifo_enq_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .fifo_enqueue (fifo_enqueue),
    .fifo_wdata   (fifo_wdata),
    .fifo_is_full (fifo_is_full),
    .busy         (busy)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Grant the model expects for the current inputs: first requester at or after the pointer
  function automatic logic [NR-1:0] model_gnt();
    int idx;
    if (!rst_n || flush) return '0;
    if (m_q.size() != 0 && fifo_is_full) return '0;
    for (int k = 0; k < NR; k++) begin
      idx = (m_ptr + k) % NR;
      if (req[idx]) return NR'(1) << idx;
    end
    return '0;
  endfunction

  always @(posedge clk) begin
    logic [NR-1:0] g;
    if (!rst_n) begin
      m_q.delete();
      m_last  = '0;
      m_ptr   = 0;
      m_gmask = '0;
    end else begin
      g = model_gnt();
      m_gmask = g;
      if (m_q.size() != 0 && !fifo_is_full) begin
        m_acc_n++;
        m_acc_sum = m_acc_sum + m_q.pop_front();
      end else if (m_q.size() != 0 && flush) begin
        m_q.delete();
        m_drop++;
      end
      for (int k = 0; k < NR; k++) begin
        if (g[k]) begin
          m_last = pdata[k];
          m_q.push_back(pdata[k]);
          m_ptr = (k + 1) % NR;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", DW'(gnt), '0);
      chk("rst_enqueue", DW'(fifo_enqueue), '0);
      chk("rst_wdata", fifo_wdata, '0);
    end else begin
      chk("gnt", DW'(gnt), DW'(model_gnt()));
      chk("enqueue", DW'(fifo_enqueue), DW'(m_q.size() != 0));
      chk("wdata", fifo_wdata, m_last);
      chk("busy", DW'(busy), DW'((m_q.size() != 0) || (|req)));
      if (fifo_enqueue && !fifo_is_full) begin
        d_acc_n++;
        d_acc_sum = d_acc_sum + fifo_wdata;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int seq = 0;

  initial begin
    for (int i = 0; i < NR; i++) pdata[i] = 64'hA0 + DW'(i);
    cyc();
    cyc();
    rst_n = 1'b1;
    #2;
    chk("post_rst_enqueue", DW'(fifo_enqueue), '0);
    chk("post_rst_wdata", fifo_wdata, '0);
    chk("post_rst_gnt", DW'(gnt), '0);

    // Load an entry, then assert reset mid-cycle
    req = 4'b0001;
    #2;
    chk("pre_rst_gnt", DW'(gnt), 64'h1);
    cyc();
    req = 4'b1111;
    #2;
    chk("held_enqueue", DW'(fifo_enqueue), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_enqueue", DW'(fifo_enqueue), '0);
    chk("async_rst_gnt", DW'(gnt), '0);
    cyc();
    rst_n = 1'b1;

    // Fairness: pointer restarted at 0
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("fair_gnt", DW'(gnt), 64'h1 << (i % 4));
      if (i > 0) chk("fair_wdata", fifo_wdata, 64'hA0 + DW'((i - 1) % 4));
      cyc();
    end
    req = 4'b0000;
    #2;
    chk("fair_last_wdata", fifo_wdata, 64'hA3);
    cyc();

    // Sparse requests wrapping from pointer 3
    req = 4'b0100;
    #2;
    chk("sparse_setup", DW'(gnt), 64'h4);
    cyc();
    req = 4'b0101;
    #2; chk("wrap_gnt0", DW'(gnt), 64'h1); cyc();
    #2; chk("wrap_gnt1", DW'(gnt), 64'h4); cyc();
    #2; chk("wrap_gnt2", DW'(gnt), 64'h1); cyc();

    // Backpressure with A0 held
    req = 4'b0010;
    fifo_is_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("bp_gnt", DW'(gnt), '0);
      chk("bp_enqueue", DW'(fifo_enqueue), 64'h1);
      chk("bp_wdata", fifo_wdata, 64'hA0);
      cyc();
    end
    fifo_is_full = 1'b0;
    #2;
    chk("bp_release_gnt", DW'(gnt), 64'h2);
    cyc();
    #2;
    chk("bp_release_wdata", fifo_wdata, 64'hA1);

    // Flush while the FIFO is full drops the held entry
    pdata[1] = 64'hB1;
    flush = 1'b1;
    fifo_is_full = 1'b1;
    #1;
    chk("flush_gnt", DW'(gnt), '0);
    cyc();
    flush = 1'b0;
    fifo_is_full = 1'b0;
    #2;
    chk("flush_enqueue", DW'(fifo_enqueue), '0);
    chk("post_flush_gnt", DW'(gnt), 64'h2);
    cyc();
    #2;
    chk("post_flush_wdata", fifo_wdata, 64'hB1);
    req = 4'b0000;
    cyc();
    cyc();

    // Random requests, backpressure and flushes
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (m_gmask[i]) begin
          seq++;
          pdata[i] = {8'(i), 24'h0, 32'(seq)};
          req[i] = 1'($urandom_range(0, 1));
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          seq++;
          pdata[i] = {8'(i), 24'h0, 32'(seq)};
          req[i] = 1'b1;
        end
      end
      fifo_is_full = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 15) == 0);
      cyc();
    end
    req = '0;
    flush = 1'b0;
    fifo_is_full = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("sb_accept_count", DW'(d_acc_n), DW'(m_acc_n));
    chk("sb_accept_sum", d_acc_sum, m_acc_sum);
    chk("sb_idle_enqueue", DW'(fifo_enqueue), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
